// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package control_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb
    } state_e;

    // Instruction class; lets the FSM branch without re-decoding raw opcode bits.
    typedef enum logic [2:0] {
        ClsR,
        ClsIAlu,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsJ,
        ClsBad
    } op_cls_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational (opcode, funct) -> ALU control, instruction class and legality.
module alu_decoder
    import control_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned ALUC_W   = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUC_W-1:0]   aluc,
    output logic                legal,
    output op_cls_e             op_cls
);

    always_comb begin
        aluc   = ALUC_W'(ALUC_ADD);
        op_cls = ClsBad;
        case (opcode)
            OPCODE_W'(OP_RTYPE): begin
                op_cls = ClsR;
                case (funct)
                    FUNCT_W'(FN_ADD): aluc = ALUC_W'(ALUC_ADD);
                    FUNCT_W'(FN_SUB): aluc = ALUC_W'(ALUC_SUB);
                    FUNCT_W'(FN_AND): aluc = ALUC_W'(ALUC_AND);
                    FUNCT_W'(FN_OR):  aluc = ALUC_W'(ALUC_OR);
                    FUNCT_W'(FN_SLT): aluc = ALUC_W'(ALUC_SLT);
                    default:          op_cls = ClsBad;
                endcase
            end
            OPCODE_W'(OP_ADDI): begin op_cls = ClsIAlu; aluc = ALUC_W'(ALUC_ADD); end
            OPCODE_W'(OP_ANDI): begin op_cls = ClsIAlu; aluc = ALUC_W'(ALUC_AND); end
            OPCODE_W'(OP_ORI):  begin op_cls = ClsIAlu; aluc = ALUC_W'(ALUC_OR);  end
            OPCODE_W'(OP_SLTI): begin op_cls = ClsIAlu; aluc = ALUC_W'(ALUC_SLT); end
            OPCODE_W'(OP_LW):   begin op_cls = ClsLw;   aluc = ALUC_W'(ALUC_ADD); end
            OPCODE_W'(OP_SW):   begin op_cls = ClsSw;   aluc = ALUC_W'(ALUC_ADD); end
            OPCODE_W'(OP_BEQ):  begin op_cls = ClsBeq;  aluc = ALUC_W'(ALUC_SUB); end
            OPCODE_W'(OP_J):    begin op_cls = ClsJ;    aluc = ALUC_W'(ALUC_ADD); end
            default:            op_cls = ClsBad;
        endcase
        legal = (op_cls != ClsBad);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with memory-ready timeout
// and a retired-instruction counter.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned FUNCT_W     = 6,
    parameter int unsigned ALUC_W      = 3,
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] OpCode,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                IR_En,
    output logic                PC_En,
    output logic                PC_Cond,
    output logic [1:0]          PcSrc,
    output logic                BR_En,
    output logic                Mux1,
    output logic                Mux2,
    output logic                Mux3,
    output logic [ALUC_W-1:0]   AluC,
    output logic                EnW,
    output logic                EnR,
    output logic                Illegal,
    output logic                MemErr,
    output logic [CNT_W-1:0]    InstrCount
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [FUNCT_W-1:0]  fn_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                retire;
    logic                mem_done;
    logic                mem_timeout;

    logic [OPCODE_W-1:0] dec_op;
    logic [FUNCT_W-1:0]  dec_fn;
    logic [ALUC_W-1:0]   dec_aluc;
    logic                dec_legal;
    op_cls_e             dec_cls;

    // The branch decision is made by the datapath from PC_Cond and Zero.
    logic unused_zero;
    assign unused_zero = Zero;

    // DECODE judges the live IR fields; later states use the latched copy.
    assign dec_op = (state_q == StDecode) ? OpCode : op_q;
    assign dec_fn = (state_q == StDecode) ? Funct  : fn_q;

    alu_decoder #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W),
        .ALUC_W   (ALUC_W)
    ) u_alu_decoder (
        .opcode (dec_op),
        .funct  (dec_fn),
        .aluc   (dec_aluc),
        .legal  (dec_legal),
        .op_cls (dec_cls)
    );

    assign mem_done    = (state_q == StMem) && MemReady;
    assign mem_timeout = (state_q == StMem) && !MemReady &&
                         (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    assign InstrCount  = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            fn_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == StDecode) begin
                op_q <= OpCode;
                fn_q <= Funct;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        retire  = 1'b0;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: state_d = dec_legal ? StExec : StFetch;
            StExec: begin
                wait_d = '0;
                case (dec_cls)
                    ClsBeq, ClsJ: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                    ClsLw, ClsSw: state_d = StMem;
                    default:      state_d = StWb;
                endcase
            end
            StMem: begin
                if (mem_done) begin
                    if (dec_cls == ClsSw) begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end else begin
                        state_d = StWb;
                    end
                end else if (mem_timeout) begin
                    state_d = StFetch;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        IR_En   = 1'b0;
        PC_En   = 1'b0;
        PC_Cond = 1'b0;
        PcSrc   = PCSRC_SEQ;
        BR_En   = 1'b0;
        Mux1    = 1'b0;
        Mux2    = 1'b0;
        Mux3    = 1'b0;
        AluC    = '0;
        EnW     = 1'b0;
        EnR     = 1'b0;
        Illegal = 1'b0;
        MemErr  = 1'b0;
        unique case (state_q)
            StFetch: begin
                IR_En = 1'b1;
                PC_En = 1'b1;
                PcSrc = PCSRC_SEQ;
                AluC  = ALUC_W'(ALUC_ADD);
            end
            StDecode: Illegal = !dec_legal;
            StExec: begin
                AluC = dec_aluc;
                case (dec_cls)
                    ClsIAlu, ClsLw, ClsSw: Mux2 = 1'b1;
                    ClsBeq: begin
                        PC_Cond = 1'b1;
                        PcSrc   = PCSRC_BRANCH;
                    end
                    ClsJ: begin
                        PC_En = 1'b1;
                        PcSrc = PCSRC_JUMP;
                    end
                    default: Mux2 = 1'b0;
                endcase
            end
            StMem: begin
                EnR    = (dec_cls == ClsLw);
                EnW    = (dec_cls == ClsSw);
                Mux2   = 1'b1;
                AluC   = ALUC_W'(ALUC_ADD);
                MemErr = mem_timeout;
            end
            StWb: begin
                BR_En = 1'b1;
                Mux1  = (dec_cls == ClsR);
                Mux3  = (dec_cls == ClsLw);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench: per-instruction cycle traces built from the instruction-set rules,
// replayed against the controller with randomized instructions and memory waits.
module tb_multicycle_control_unit;

    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;

    localparam logic [5:0] LEGAL_OPS [9] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101,
                                             6'b001010, 6'b100011, 6'b101011, 6'b000100,
                                             6'b000010};
    localparam logic [5:0] LEGAL_FNS [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                             6'b101010};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    OpCode = '0;
    logic [5:0]    Funct = '0;
    logic          Zero = 1'b0;
    logic          MemReady = 1'b0;
    logic          IR_En, PC_En, PC_Cond, BR_En, Mux1, Mux2, Mux3, EnW, EnR, Illegal, MemErr;
    logic [1:0]    PcSrc;
    logic [2:0]    AluC;
    logic [CW-1:0] InstrCount;

    multicycle_control_unit #(
        .OPCODE_W    (6),
        .FUNCT_W     (6),
        .ALUC_W      (3),
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .OpCode     (OpCode),
        .Funct      (Funct),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .IR_En      (IR_En),
        .PC_En      (PC_En),
        .PC_Cond    (PC_Cond),
        .PcSrc      (PcSrc),
        .BR_En      (BR_En),
        .Mux1       (Mux1),
        .Mux2       (Mux2),
        .Mux3       (Mux3),
        .AluC       (AluC),
        .EnW        (EnW),
        .EnR        (EnR),
        .Illegal    (Illegal),
        .MemErr     (MemErr),
        .InstrCount (InstrCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic       pc_cond;
        logic [1:0] pc_src;
        logic       br_en;
        logic       mux1;
        logic       mux2;
        logic       mux3;
        logic [2:0] aluc;
        logic       en_w;
        logic       en_r;
        logic       illegal;
        logic       mem_err;
    } ctl_t;

    // ph: 0 idle, 1 fetch, 2 decode, 3 exec, 4 mem, 5 wb
    typedef struct packed {
        ctl_t       exp;
        ctl_t       care;
        logic       rdy;
        logic       rst;
        logic       ir_live;
        logic       retire;
        logic       chk;
        logic [5:0] op;
        logic [5:0] fn;
        logic [2:0] ph;
    } step_t;

    step_t         q[$];
    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] model_cnt = '0;

    function automatic ctl_t wr_care();
        ctl_t c;
        c = '0;
        c.ir_en = 1'b1; c.pc_en = 1'b1; c.pc_cond = 1'b1; c.br_en = 1'b1;
        c.en_w = 1'b1; c.en_r = 1'b1; c.illegal = 1'b1; c.mem_err = 1'b1;
        return c;
    endfunction

    function automatic step_t mk(input logic [2:0] ph);
        step_t s;
        s = '0;
        s.care = wr_care();
        s.chk = 1'b1;
        s.ph = ph;
        return s;
    endfunction

    function automatic string ph_name(input logic [2:0] ph);
        case (ph)
            3'd0: return "idle";
            3'd1: return "fetch";
            3'd2: return "decode";
            3'd3: return "exec";
            3'd4: return "mem";
            default: return "wb";
        endcase
    endfunction

    // kind: 0 illegal, 1 R, 2 I-ALU, 3 LW, 4 SW, 5 BEQ, 6 J.
    // waits = not-ready MEM cycles before MemReady; waits >= TO means it never comes.
    task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int waits);
        step_t      s;
        int         kind;
        logic [2:0] alu;
        kind = 0;
        alu = 3'b010;
        case (op)
            6'b000000: case (fn)
                6'b100000: begin kind = 1; alu = 3'b010; end
                6'b100010: begin kind = 1; alu = 3'b110; end
                6'b100100: begin kind = 1; alu = 3'b000; end
                6'b100101: begin kind = 1; alu = 3'b001; end
                6'b101010: begin kind = 1; alu = 3'b111; end
                default:   kind = 0;
            endcase
            6'b001000: begin kind = 2; alu = 3'b010; end
            6'b001100: begin kind = 2; alu = 3'b000; end
            6'b001101: begin kind = 2; alu = 3'b001; end
            6'b001010: begin kind = 2; alu = 3'b111; end
            6'b100011: kind = 3;
            6'b101011: kind = 4;
            6'b000100: begin kind = 5; alu = 3'b110; end
            6'b000010: kind = 6;
            default:   kind = 0;
        endcase

        s = mk(3'd1);
        s.exp.ir_en = 1'b1; s.exp.pc_en = 1'b1; s.exp.aluc = 3'b010; s.care = '1;
        q.push_back(s);

        s = mk(3'd2);
        s.ir_live = 1'b1; s.op = op; s.fn = fn; s.exp.illegal = (kind == 0);
        q.push_back(s);
        if (kind == 0) return;

        s = mk(3'd3);
        case (kind)
            1, 2, 3, 4: begin
                s.exp.mux2 = (kind != 1); s.care.mux2 = 1'b1;
                s.exp.aluc = alu; s.care.aluc = '1;
            end
            5: begin
                s.exp.aluc = alu; s.care.aluc = '1;
                s.exp.pc_cond = 1'b1; s.exp.pc_src = 2'b01; s.care.pc_src = '1;
                s.retire = 1'b1;
            end
            default: begin
                s.exp.pc_en = 1'b1; s.exp.pc_src = 2'b10; s.care.pc_src = '1;
                s.retire = 1'b1;
            end
        endcase
        q.push_back(s);
        if (kind >= 5) return;

        if (kind == 3 || kind == 4) begin
            for (int i = 0; i < int'(TO); i++) begin
                s = mk(3'd4);
                s.rdy = (i == waits);
                s.exp.en_r = (kind == 3); s.exp.en_w = (kind == 4);
                s.exp.mux2 = 1'b1; s.care.mux2 = 1'b1;
                s.exp.aluc = 3'b010; s.care.aluc = '1;
                if (!s.rdy && i == int'(TO) - 1) s.exp.mem_err = 1'b1;
                if (s.rdy && kind == 4) s.retire = 1'b1;
                q.push_back(s);
                if (s.rdy) break;
                if (i == int'(TO) - 1) return;
            end
            if (kind == 4) return;
        end

        s = mk(3'd5);
        s.exp.br_en = 1'b1;
        s.exp.mux1 = (kind == 1); s.care.mux1 = 1'b1;
        s.exp.mux3 = (kind == 3); s.care.mux3 = 1'b1;
        s.retire = 1'b1;
        q.push_back(s);
    endtask

    task automatic add_reset(input logic check_first);
        step_t s;
        s = mk(3'd0); s.rst = 1'b1; s.chk = check_first; s.care = '1; q.push_back(s);
        s = mk(3'd0); s.rst = 1'b1; s.care = '1; q.push_back(s);
        s = mk(3'd0); s.care = '1; q.push_back(s);
    endtask

    // LW stalls in MEM; reset arrives together with MemReady.
    task automatic add_reset_mid_mem();
        step_t s;
        add_instr(6'b100011, 6'b000000, TO);
        while (q.size() > 0 && q[q.size()-1].ph == 3'd4) void'(q.pop_back());
        s = mk(3'd4);
        s.exp.en_r = 1'b1; s.exp.mux2 = 1'b1; s.care.mux2 = 1'b1;
        s.exp.aluc = 3'b010; s.care.aluc = '1;
        q.push_back(s);
        s.rst = 1'b1; s.rdy = 1'b1;
        q.push_back(s);
        s = mk(3'd0); s.care = '1; q.push_back(s);
    endtask

    task automatic run_steps();
        step_t s;
        ctl_t  obs;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            rst = s.rst;
            MemReady = (s.ph == 3'd4) ? s.rdy : 1'($urandom);
            Zero = 1'($urandom);
            OpCode = s.ir_live ? s.op : 6'($urandom);
            Funct = s.ir_live ? s.fn : 6'($urandom);
            #1;
            if (s.chk) begin
                obs = {IR_En, PC_En, PC_Cond, PcSrc, BR_En, Mux1, Mux2, Mux3, AluC,
                       EnW, EnR, Illegal, MemErr};
                checks++;
                assert ((obs & s.care) === (s.exp & s.care)) else begin
                    failures++;
                    $error("FAIL ctl_%s op=%b fn=%b observed=%h expected=%h care=%h",
                           ph_name(s.ph), OpCode, Funct, obs, s.exp, s.care);
                end
                checks++;
                assert (InstrCount === model_cnt) else begin
                    failures++;
                    $error("FAIL count_%s observed=%0d expected=%0d",
                           ph_name(s.ph), InstrCount, model_cnt);
                end
            end
            if (s.rst) model_cnt = '0;
            else if (s.retire) model_cnt = model_cnt + 1'b1;
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        int         waits;

        add_reset(1'b0);
        run_steps();

        add_instr(6'b000000, 6'b100010, 0);        // R SUB
        run_steps();
        add_instr(6'b100011, 6'b000000, 3);        // LW, ready after 3 waits
        run_steps();
        add_instr(6'b101011, 6'b000000, TO);       // SW timeout
        run_steps();
        add_instr(6'b000100, 6'b000000, 0);        // BEQ
        add_instr(6'b000010, 6'b000000, 0);        // J
        run_steps();
        add_instr(6'b111111, 6'b000000, 0);        // bad opcode
        add_instr(6'b000000, 6'b000111, 0);        // bad funct
        run_steps();
        add_instr(6'b100011, 6'b000000, TO - 1);   // ready on terminal count
        add_instr(6'b101011, 6'b000000, 0);
        add_instr(6'b001000, 6'b000000, 0);
        add_instr(6'b001100, 6'b000000, 0);
        add_instr(6'b001101, 6'b000000, 0);
        add_instr(6'b001010, 6'b000000, 0);
        run_steps();

        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else op = LEGAL_OPS[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
            else fn = LEGAL_FNS[$urandom_range(0, 4)];
            waits = int'($urandom_range(0, TO + 1));
            add_instr(op, fn, waits);
            run_steps();
        end

        add_reset_mid_mem();
        add_instr(6'b000000, 6'b100101, 0);
        run_steps();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
